// File: rtl/conv_bcd_secvential_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// controller state encoding and the width of one decimal digit.
package conv_bcd_secvential_pkg;

  localparam int LATIME_CIFRA = 4;

  typedef enum logic [1:0] {
    INACTIV   = 2'd0,
    CONVERSIE = 2'd1,
    GATA      = 2'd2
  } stare_t;

endpackage

// File: rtl/conv_bcd_secvential_corectie_cifra.sv
// Double-dabble digit correction: a digit above 4 gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module corectie_cifra
  import conv_bcd_secvential_pkg::*;
(
  input  logic [LATIME_CIFRA-1:0] cifra,
  output logic [LATIME_CIFRA-1:0] cifra_corectata
);

  // Add 3 to digits 5..9; smaller digits pass unchanged.
  always_comb begin
    cifra_corectata = (cifra > 4'd4) ? (cifra + 4'd3) : cifra;
  end

endmodule

// File: rtl/conv_bcd_secvential.sv
// Sequential binary-to-BCD converter (shift-and-add-3). One operand bit is
// consumed per cycle; the result is saturated to all nines when the operand
// does not fit in NR_CIFRE decimal digits.
module conv_bcd_secvential
  import conv_bcd_secvential_pkg::*;
#(
  parameter int LATIME   = 6,
  parameter int NR_CIFRE = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [LATIME-1:0]                valoare_bin,
  output logic [LATIME_CIFRA*NR_CIFRE-1:0] bcd,
  output logic                             ocupat,
  output logic                             gata,
  output logic                             depasire
);

  localparam int LC = LATIME_CIFRA * NR_CIFRE;
  localparam int CW = $clog2(LATIME + 1);
  localparam logic [CW-1:0] CONTOR_START = CW'(LATIME);
  localparam logic [CW-1:0] CONTOR_UNU   = CW'(1);
  localparam logic [LC-1:0] TOT_NOUA     = {NR_CIFRE{4'd9}};

  stare_t            stare_r;
  logic [CW-1:0]     contor_r;
  logic [LATIME-1:0] operand_r;
  logic [LC-1:0]     cifre_r;
  logic              depasire_int_r;

  logic [LC-1:0]        corectat_s;
  logic [LC+LATIME-1:0] deplasat_s;
  logic [LC-1:0]        cifre_urm_s;
  logic [LATIME-1:0]    operand_urm_s;
  logic                 depasire_urm_s;
  logic [LC-1:0]        bcd_final_s;

  // One correction cell per decimal digit.
  for (genvar g = 0; g < NR_CIFRE; g++) begin : g_corectie
    corectie_cifra u_corectie (
      .cifra           (cifre_r[g*LATIME_CIFRA +: LATIME_CIFRA]),
      .cifra_corectata (corectat_s[g*LATIME_CIFRA +: LATIME_CIFRA])
    );
  end

  // Next shift step: corrected digits and operand move left by one bit; the
  // bit leaving the top digit feeds the sticky overflow flag.
  always_comb begin
    deplasat_s     = {corectat_s[LC-2:0], operand_r, 1'b0};
    cifre_urm_s    = deplasat_s[LC+LATIME-1:LATIME];
    operand_urm_s  = deplasat_s[LATIME-1:0];
    depasire_urm_s = depasire_int_r | corectat_s[LC-1];
    bcd_final_s    = depasire_urm_s ? TOT_NOUA : cifre_urm_s;
  end

  // Controller, datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stare_r        <= INACTIV;
      contor_r       <= '0;
      operand_r      <= '0;
      cifre_r        <= '0;
      depasire_int_r <= 1'b0;
      bcd            <= '0;
      ocupat         <= 1'b0;
      gata           <= 1'b0;
      depasire       <= 1'b0;
    end else begin
      case (stare_r)
        INACTIV, GATA: begin
          gata <= 1'b0;
          if (start) begin
            operand_r      <= valoare_bin;
            cifre_r        <= '0;
            depasire_int_r <= 1'b0;
            contor_r       <= CONTOR_START;
            ocupat         <= 1'b1;
            stare_r        <= CONVERSIE;
          end else begin
            ocupat  <= 1'b0;
            stare_r <= INACTIV;
          end
        end
        CONVERSIE: begin
          operand_r      <= operand_urm_s;
          cifre_r        <= cifre_urm_s;
          depasire_int_r <= depasire_urm_s;
          contor_r       <= contor_r - CONTOR_UNU;
          if (contor_r == CONTOR_UNU) begin
            // Last bit: publish the result on the same edge as the shift.
            bcd      <= bcd_final_s;
            depasire <= depasire_urm_s;
            ocupat   <= 1'b0;
            gata     <= 1'b1;
            stare_r  <= GATA;
          end else begin
            ocupat  <= 1'b1;
            stare_r <= CONVERSIE;
          end
        end
        default: begin
          ocupat  <= 1'b0;
          gata    <= 1'b0;
          stare_r <= INACTIV;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_bcd_secvential.sv
// Self-checking bench: four converter instances with different widths, a
// cycle-level behavioural model based on decimal arithmetic, directed
// scenarios with literal expectations and a randomized sweep.
module tb_conv_bcd_secvential;

  localparam int L_A [4] = '{6, 16, 8, 12};
  localparam int N_A [4] = '{2, 5, 2, 4};

  logic        clk;
  logic        rst;
  logic        start_a [4];
  logic [31:0] val_a   [4];
  logic        ocup_a  [4];
  logic        gata_a  [4];
  logic        dep_a   [4];
  logic [39:0] bcd_a   [4];

  logic [7:0]  bcd0;
  logic [19:0] bcd1;
  logic [7:0]  bcd2;
  logic [15:0] bcd3;

  int checks = 0;
  int failures = 0;

  // model state per instance
  int              m_busy [4];
  longint unsigned m_op   [4];
  logic [39:0]     m_bcd  [4];
  logic            m_dep  [4];
  logic            m_g    [4];
  logic            m_oc   [4];

  conv_bcd_secvential #(.LATIME(6), .NR_CIFRE(2)) u0 (
    .clk(clk), .rst(rst), .start(start_a[0]), .valoare_bin(val_a[0][5:0]),
    .bcd(bcd0), .ocupat(ocup_a[0]), .gata(gata_a[0]), .depasire(dep_a[0]));
  conv_bcd_secvential #(.LATIME(16), .NR_CIFRE(5)) u1 (
    .clk(clk), .rst(rst), .start(start_a[1]), .valoare_bin(val_a[1][15:0]),
    .bcd(bcd1), .ocupat(ocup_a[1]), .gata(gata_a[1]), .depasire(dep_a[1]));
  conv_bcd_secvential #(.LATIME(8), .NR_CIFRE(2)) u2 (
    .clk(clk), .rst(rst), .start(start_a[2]), .valoare_bin(val_a[2][7:0]),
    .bcd(bcd2), .ocupat(ocup_a[2]), .gata(gata_a[2]), .depasire(dep_a[2]));
  conv_bcd_secvential #(.LATIME(12), .NR_CIFRE(4)) u3 (
    .clk(clk), .rst(rst), .start(start_a[3]), .valoare_bin(val_a[3][11:0]),
    .bcd(bcd3), .ocupat(ocup_a[3]), .gata(gata_a[3]), .depasire(dep_a[3]));

  assign bcd_a[0] = {32'd0, bcd0};
  assign bcd_a[1] = {20'd0, bcd1};
  assign bcd_a[2] = {32'd0, bcd2};
  assign bcd_a[3] = {24'd0, bcd3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Decimal reference: exact digits, or all nines plus overflow flag.
  function automatic void ref_conv(input longint unsigned v, input int n,
                                   output logic [39:0] b, output logic d);
    longint unsigned lim = 1;
    longint unsigned x = v;
    for (int k = 0; k < n; k++) lim = lim * 10;
    b = '0;
    if (x >= lim) begin
      d = 1'b1;
      for (int k = 0; k < n; k++) b[4*k +: 4] = 4'd9;
    end else begin
      d = 1'b0;
      for (int k = 0; k < n; k++) begin
        b[4*k +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
  endfunction

  // Behavioural model: L cycles busy after an accepted start, then a one
  // cycle done pulse carrying the decimal value of the captured operand.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        m_busy[i] = 0; m_op[i] = 0; m_bcd[i] = '0;
        m_dep[i] = 1'b0; m_g[i] = 1'b0; m_oc[i] = 1'b0;
      end else if (m_busy[i] > 0) begin
        m_busy[i] = m_busy[i] - 1;
        m_oc[i] = (m_busy[i] > 0);
        m_g[i] = (m_busy[i] == 0);
        if (m_busy[i] == 0) ref_conv(m_op[i], N_A[i], m_bcd[i], m_dep[i]);
      end else begin
        m_g[i] = 1'b0;
        if (start_a[i]) begin
          m_op[i] = longint'(val_a[i]) & ((64'd1 << L_A[i]) - 64'd1);
          m_busy[i] = L_A[i];
          m_oc[i] = 1'b1;
        end else begin
          m_oc[i] = 1'b0;
        end
      end
    end
  end

  // Compare every instance against the model on every falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("u%0d.ocupat", i), 64'(ocup_a[i]), 64'(m_oc[i]));
      chk($sformatf("u%0d.gata", i), 64'(gata_a[i]), 64'(m_g[i]));
      chk($sformatf("u%0d.bcd", i), 64'(bcd_a[i]), 64'(m_bcd[i]));
      chk($sformatf("u%0d.depasire", i), 64'(dep_a[i]), 64'(m_dep[i]));
    end
  end

  task automatic pulse_start(input int i, input logic [31:0] v);
    @(negedge clk);
    start_a[i] = 1'b1;
    val_a[i] = v;
    @(negedge clk);
    start_a[i] = 1'b0;
    val_a[i] = $urandom;
  endtask

  task automatic wait_gata(input int i, output int cyc, output int noc);
    cyc = 0;
    noc = 0;
    while (gata_a[i] !== 1'b1 && cyc < 200) begin
      if (ocup_a[i]) noc++;
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("u%0d.gata_seen", i), 64'(gata_a[i]), 64'd1);
  endtask

  int cyc, noc, ng, conv3, guard;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_a[i] = 1'b0;
      val_a[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst.u%0d.bcd", i), 64'(bcd_a[i]), 64'd0);
      chk($sformatf("rst.u%0d.busy", i), 64'({ocup_a[i], gata_a[i], dep_a[i]}), 64'd0);
    end
    rst = 1'b0;

    // Default instance, 63 -> 0x63 after 6 cycles, busy exactly 6 cycles.
    pulse_start(0, 32'd63);
    wait_gata(0, cyc, noc);
    chk("d63.latency", 64'(cyc), 64'd6);
    chk("d63.ocupat_cycles", 64'(noc), 64'd6);
    chk("d63.bcd", 64'(bcd0), 64'h63);
    chk("d63.depasire", 64'(dep_a[0]), 64'd0);

    // Wide instance: 65535 and 0.
    pulse_start(1, 32'd65535);
    wait_gata(1, cyc, noc);
    chk("w65535.latency", 64'(cyc), 64'd16);
    chk("w65535.bcd", 64'(bcd1), 64'h65535);
    chk("w65535.depasire", 64'(dep_a[1]), 64'd0);
    pulse_start(1, 32'd0);
    wait_gata(1, cyc, noc);
    chk("w0.latency", 64'(cyc), 64'd16);
    chk("w0.bcd", 64'(bcd1), 64'h00000);

    // Overflow saturation and recovery.
    pulse_start(2, 32'd200);
    wait_gata(2, cyc, noc);
    chk("o200.bcd", 64'(bcd2), 64'h99);
    chk("o200.depasire", 64'(dep_a[2]), 64'd1);
    pulse_start(2, 32'd99);
    wait_gata(2, cyc, noc);
    chk("o99.bcd", 64'(bcd2), 64'h99);
    chk("o99.depasire", 64'(dep_a[2]), 64'd0);

    // Start during conversion is ignored; start in the done cycle is taken.
    pulse_start(0, 32'd42);
    @(negedge clk);
    start_a[0] = 1'b1;
    val_a[0] = 32'd17;
    @(negedge clk);
    start_a[0] = 1'b0;
    wait_gata(0, cyc, noc);
    chk("ign.latency", 64'(cyc), 64'd4);
    chk("ign.bcd", 64'(bcd0), 64'h42);
    start_a[0] = 1'b1;
    val_a[0] = 32'd17;
    @(negedge clk);
    start_a[0] = 1'b0;
    val_a[0] = $urandom;
    wait_gata(0, cyc, noc);
    chk("b2b.latency", 64'(cyc), 64'd6);
    chk("b2b.bcd", 64'(bcd0), 64'h17);

    // Reset mid-conversion aborts without a done pulse.
    pulse_start(0, 32'd50);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rstmid.outs", 64'({bcd0, ocup_a[0], gata_a[0], dep_a[0]}), 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    ng = 0;
    repeat (10) begin
      @(negedge clk);
      if (gata_a[0]) ng++;
    end
    chk("rstmid.no_gata", 64'(ng), 64'd0);
    pulse_start(0, 32'd7);
    wait_gata(0, cyc, noc);
    chk("after_rst.latency", 64'(cyc), 64'd6);
    chk("after_rst.bcd", 64'(bcd0), 64'h07);

    // Randomized sweep; the model comparison runs every cycle.
    conv3 = 0;
    guard = 0;
    while (conv3 < 1000 && guard < 40000) begin
      @(negedge clk);
      guard++;
      if (gata_a[3]) conv3++;
      for (int i = 0; i < 4; i++) begin
        if (i != 1) begin
          start_a[i] = (($urandom % 4) != 0);
          val_a[i] = $urandom;
        end
      end
    end
    chk("sweep.conversions", 64'(conv3), 64'd1000);
    for (int i = 0; i < 4; i++) start_a[i] = 1'b0;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_bcd_secvential.md
CONV_BCD_SECVENTIAL -- requirements
Module: conv_bcd_secvential

Interface
REQ-001 The module SHALL have parameter LATIME, default 6, meaning the binary input width in bits; legal range 1..32.
REQ-002 The module SHALL have parameter NR_CIFRE, default 2, meaning the number of BCD output digits; legal range 1..10.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The module SHALL have port start, input, 1 bit: a conversion request, sampled on the clk rising edge.
REQ-006 The module SHALL have port valoare_bin, input, LATIME bits: the unsigned binary operand, sampled on the edge at which start is accepted.
REQ-007 The module SHALL have port bcd, output, 4*NR_CIFRE bits: the registered result; bcd[3:0] is the least significant digit.
REQ-008 The module SHALL have port ocupat, output, 1 bit: high while a conversion is in progress.
REQ-009 The module SHALL have port gata, output, 1 bit: a one-cycle pulse marking that a new bcd value is valid.
REQ-010 The module SHALL have port depasire, output, 1 bit: high when the last operand exceeded 10^NR_CIFRE - 1; registered together with bcd.

Function
REQ-011 The module SHALL implement the states INACTIV, CONVERSIE and GATA.
REQ-012 In INACTIV or GATA with start=1, the module SHALL latch valoare_bin into the shift register, clear the digit register and the overflow flag, load the bit counter with LATIME, and enter CONVERSIE.
REQ-013 In INACTIV or GATA with start=0, the module SHALL enter INACTIV.
REQ-014 Each CONVERSIE cycle SHALL add 3 to every digit greater than 4, then shift {digits, operand} left by one bit.
REQ-015 Each CONVERSIE cycle SHALL decrement the bit counter.
REQ-016 The bit shifted out of the top digit SHALL be ORed into a sticky overflow flag.
REQ-017 After exactly LATIME CONVERSIE cycles, the module SHALL enter GATA.
REQ-018 The GATA transition SHALL update bcd and depasire on the same edge.
REQ-019 Latency: start is sampled at edge N; ocupat is high during cycles N+1..N+LATIME; gata is high during cycle N+LATIME+1 only.
REQ-020 The module SHALL ignore start while in CONVERSIE; the operand SHALL NOT change mid-conversion.
REQ-021 start asserted during GATA SHALL be accepted (back-to-back operation); gata SHALL still pulse for the completed result.
REQ-022 On overflow, bcd SHALL saturate to all digits 9 and depasire SHALL be 1; otherwise bcd SHALL be the exact decimal value and depasire SHALL be 0.
REQ-023 bcd and depasire SHALL hold their value until the next GATA; they SHALL NOT change during CONVERSIE.
REQ-024 An input of 0 SHALL produce bcd all zeros, depasire=0, and the normal latency.
REQ-025 No digit SHALL ever hold a value above 9 on bcd.

Reset
REQ-026 While rst=1, the module SHALL be in state INACTIV, regardless of clk.
REQ-027 While rst=1, bcd, ocupat, gata, depasire, the counter and the shift register SHALL all be 0, regardless of clk.
REQ-028 Reset asserted mid-conversion SHALL abort the conversion with no gata pulse.
REQ-029 The first start after reset release SHALL behave normally.

Structure
REQ-030 A shared package SHALL hold the state enumeration (INACTIV, CONVERSIE, GATA) and the constant LATIME_CIFRA=4.
REQ-031 The module SHALL contain one sub-module, corectie_cifra: combinational, 4-bit in/out, adds 3 when the input is greater than 4, instantiated NR_CIFRE times through generate.
REQ-032 The counter width SHALL be clog2(LATIME+1).

Verification
REQ-033 Defaults, start with valoare_bin=63 -> after 6 cycles gata=1, bcd=0x63, depasire=0; ocupat high for exactly 6 cycles.
REQ-034 LATIME=16, NR_CIFRE=5, valoare_bin=65535 -> after 16 cycles bcd=0x65535, depasire=0; a repeat with 0 -> bcd=0x00000.
REQ-035 LATIME=8, NR_CIFRE=2, valoare_bin=200 -> bcd=0x99, depasire=1; then valoare_bin=99 -> bcd=0x99, depasire=0.
REQ-036 Defaults: start with 42, then start pulsed with 17 in cycle 3 -> ignored, result bcd=0x42; start held high in the GATA cycle with 17 -> second gata after 6 more cycles with bcd=0x17.
REQ-037 Defaults: start with 50, rst pulsed in cycle 3 -> all outputs 0 immediately, no gata; then start with 7 -> bcd=0x07 with the normal latency.
REQ-038 Random sweep, LATIME=12, NR_CIFRE=4, 1000 operands -> bcd matches the decimal reference model and depasire=0.
